// File: rtl/case_mul_pipe_hs.sv
// case_mul_pipe_hs: stallable pipelined multiplier with per-operand signedness,
// output narrowing (wrap/saturate) and an overflow flag.
module case_mul_pipe_hs #(
  parameter int ID = 1,
  parameter int NUM_STAGE = 3,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26,
  parameter int SAT_MODE = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic [1:0]            sgn_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);
  localparam int PW = din0_WIDTH + din1_WIDTH + 2;
  localparam int XW = (PW > dout_WIDTH ? PW : dout_WIDTH) + 2;
  localparam logic signed [XW-1:0] SMAX = (XW'(1) << (dout_WIDTH - 1)) - XW'(1);
  localparam logic signed [XW-1:0] SMIN = -(XW'(1) << (dout_WIDTH - 1));
  localparam logic signed [XW-1:0] UMAX = (XW'(1) << dout_WIDTH) - XW'(1);
  if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_depth
    $fatal(1, "case_mul_pipe_hs %0d: NUM_STAGE %0d outside 1..8", ID, NUM_STAGE);
  end
  logic signed [din0_WIDTH:0] a_ext;
  logic signed [din1_WIDTH:0] b_ext;
  logic signed [PW-1:0]       p;
  logic signed [XW-1:0]       px, mx, mn;
  logic                       sg, hi, lo, ovf_c, adv;
  logic [dout_WIDTH-1:0]      res;
  logic                       v_q [NUM_STAGE];
  logic                       v_d [NUM_STAGE];
  logic [dout_WIDTH-1:0]      d_q [NUM_STAGE];
  logic [dout_WIDTH-1:0]      d_d [NUM_STAGE];
  logic                       o_q [NUM_STAGE];
  logic                       o_d [NUM_STAGE];
  assign a_ext = {sgn_mode[0] & din0[din0_WIDTH-1], din0};
  assign b_ext = {sgn_mode[1] & din1[din1_WIDTH-1], din1};
  assign p     = PW'(a_ext) * PW'(b_ext);
  assign px    = XW'(p);
  assign sg    = |sgn_mode;
  assign mx    = sg ? SMAX : UMAX;
  assign mn    = sg ? SMIN : '0;
  assign hi    = px > mx;
  assign lo    = px < mn;
  assign ovf_c = hi | lo;
  // Narrowing happens before the first register so every stage carries only dout-wide data
  assign res   = (SAT_MODE != 0 && hi) ? mx[dout_WIDTH-1:0] :
                 (SAT_MODE != 0 && lo) ? mn[dout_WIDTH-1:0] : px[dout_WIDTH-1:0];
  assign adv       = !v_q[NUM_STAGE-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[NUM_STAGE-1];
  assign dout      = d_q[NUM_STAGE-1];
  assign ovf       = o_q[NUM_STAGE-1];
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    o_d = o_q;
    if (adv) begin
      v_d[0] = in_valid;
      d_d[0] = res;
      o_d[0] = ovf_c;
      for (int i = 1; i < NUM_STAGE; i++) begin
        v_d[i] = v_q[i-1];
        d_d[i] = d_q[i-1];
        o_d[i] = o_q[i-1];
      end
    end
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
        o_q[i] <= 1'b0;
      end
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      o_q <= o_d;
    end
  end
endmodule

// File: tb/tb_case_mul_pipe_hs.sv
// tb_case_mul_pipe_hs: scoreboard bench driving several configurations of
// case_mul_pipe_hs from one shared stimulus stream.
module tb_case_mul_pipe_hs;
  localparam int NI = 6;
  localparam int NS_  [NI] = '{3, 3, 3, 1, 2, 8};
  localparam int A_   [NI] = '{14, 8, 8, 14, 14, 14};
  localparam int B_   [NI] = '{12, 8, 8, 12, 12, 12};
  localparam int D_   [NI] = '{26, 8, 8, 20, 16, 26};
  localparam int SAT_ [NI] = '{0, 1, 0, 1, 0, 0};
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [13:0] din0 = '0;
  logic [11:0] din1 = '0;
  logic [1:0]  sm = '0;
  int checks = 0, failures = 0;
  event done;
  always #5 clk = ~clk;
  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  for (genvar k = 0; k < NI; k++) begin : g
    localparam int A = A_[k], B = B_[k], D = D_[k], N = NS_[k], S = SAT_[k];
    logic ir, ov, of, po, pstall = 0;
    logic [D-1:0] dq, pd;
    logic [D:0] qe [$];
    int qt [$];
    int advc = 0;
    case_mul_pipe_hs #(.ID(k), .NUM_STAGE(N), .din0_WIDTH(A), .din1_WIDTH(B),
                       .dout_WIDTH(D), .SAT_MODE(S)) u (
      .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir),
      .din0(din0[A-1:0]), .din1(din1[B-1:0]), .sgn_mode(sm),
      .out_valid(ov), .out_ready(out_ready), .dout(dq), .ovf(of));
    // Reference: exact integer product, range test against the chosen interpretation
    function automatic logic [D:0] model(input logic [13:0] x, input logic [11:0] y, input logic [1:0] m);
      longint a, b, p, mx, mn, r;
      a = longint'(x[A-1:0]);
      b = longint'(y[B-1:0]);
      if (m[0] && x[A-1]) a -= longint'(1) << A;
      if (m[1] && y[B-1]) b -= longint'(1) << B;
      p  = a * b;
      mx = (|m) ? (longint'(1) << (D - 1)) - 1 : (longint'(1) << D) - 1;
      mn = (|m) ? -(longint'(1) << (D - 1)) : 0;
      r  = (S != 0 && p > mx) ? mx : (S != 0 && p < mn) ? mn : p;
      return {p > mx || p < mn, D'(r)};
    endfunction
    always @(negedge clk) begin
      if (!rst_n) begin
        qe.delete();
        qt.delete();
        pstall = 0;
      end else begin
        chk(ir === (!ov || out_ready), $sformatf("g%0d in_ready", k), ir, !ov || out_ready);
        if (pstall) chk({of, dq} === {po, pd}, $sformatf("g%0d stall_hold", k), {of, dq}, {po, pd});
        if (ov && out_ready) begin
          if (qe.size() == 0) chk(0, $sformatf("g%0d unexpected_out", k), {of, dq}, 0);
          else begin
            logic [D:0] e;
            int t;
            e = qe.pop_front();
            t = qt.pop_front();
            chk({of, dq} === e, $sformatf("g%0d result", k), {of, dq}, e);
            chk(advc - t == N, $sformatf("g%0d latency", k), advc - t, N);
          end
        end
        if (in_valid && ir) begin
          qe.push_back(model(din0, din1, sm));
          qt.push_back(advc);
        end
        if (!ov || out_ready) advc++;
        pstall = ov && !out_ready;
        pd = dq;
        po = of;
      end
    end
    always @(done) chk(qe.size() == 0, $sformatf("g%0d drained", k), qe.size(), 0);
  end
  task automatic drive(input logic v, input logic [13:0] a, input logic [11:0] b,
                       input logic [1:0] m, input logic r);
    @(posedge clk);
    #1;
    in_valid = v; din0 = a; din1 = b; sm = m; out_ready = r;
  endtask
  task automatic rnd(input int n, input int pv, input int pr);
    for (int i = 0; i < n; i++)
      drive($urandom_range(99) < pv, 14'($urandom), 12'($urandom), 2'($urandom), $urandom_range(99) < pr);
  endtask
  logic [27:0] dir [6] = '{{2'b11, 14'h2000, 12'h800}, {2'b00, 14'h3FFF, 12'hFFF},
                           {2'b01, 14'h3FFF, 12'hFFF}, {2'b11, 14'h0080, 12'h080},
                           {2'b00, 14'h00C8, 12'h002}, {2'b11, 14'h00F0, 12'h008}};
  initial begin
    repeat (3) @(posedge clk);
    chk({g[0].ov, g[0].dq, g[0].of} === '0, "reset_outputs", {g[0].ov, g[0].dq, g[0].of}, 0);
    #2 rst_n = 1;
    #1 chk(g[0].ir === 1'b1, "reset_in_ready", g[0].ir, 1);
    for (int i = 0; i < 6; i++) drive(1, dir[i][25:12], dir[i][11:0], dir[i][27:26], 1);
    repeat (10) drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) drive(1, 14'($urandom), 12'($urandom), 2'($urandom), !(i >= 3 && i <= 5));
    repeat (12) drive(0, 0, 0, 0, 1);
    rnd(1500, 70, 70);
    repeat (12) drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 14'($urandom), 12'($urandom), 2'($urandom), 1);
    drive(0, 0, 0, 0, 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1 chk({g[0].ov, g[0].dq, g[0].of} === '0, "async_reset", {g[0].ov, g[0].dq, g[0].of}, 0);
    @(posedge clk);
    #2 rst_n = 1;
    repeat (10) drive(0, 0, 0, 0, 1);
    drive(1, 14'h2000, 12'h800, 2'b11, 1);
    rnd(300, 60, 80);
    repeat (30) drive(0, 0, 0, 0, 1);
    ->done;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/case_mul_pipe_hs.md
# case_mul_pipe_hs

Parametrised, pipelined integer multiplier with a valid/ready handshake on both sides. It is the stallable successor to the fixed-function `case_*_mul_*` multiplier cores. It adds:
- configurable latency;
- per-operand signed/unsigned selection at runtime;
- output narrowing with wrap or saturate policy;
- an overflow flag.

It sits between HLS-generated datapath stages wherever a multiply must tolerate downstream backpressure.

## Interface

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 3, pipeline depth in register stages; legal range 1..8, anything else is a simulation-time fatal error.
- din0_WIDTH, 14, width of operand 0.
- din1_WIDTH, 12, width of operand 1.
- dout_WIDTH, 26, width of result.
- SAT_MODE, 0, overflow policy: 0 = wrap (keep low bits), 1 = saturate.

Ports:
- ap_clk  in  1  clock; all state updates on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts operands this cycle.
- din0  in  din0_WIDTH  operand 0.
- din1  in  din1_WIDTH  operand 1.
- sgn_mode  in  2  bit0 = din0 signed, bit1 = din1 signed; sampled with operands.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- dout  out  dout_WIDTH  result.
- ovf  out  1  result not representable in dout_WIDTH; qualified by out_valid.

## Operation

- **Accept:** accept occurs on an edge with in_valid && in_ready. din0, din1 and sgn_mode are captured together.
- **Operand extension:** each operand is extended by one bit, sign-extended if its sgn_mode bit is 1 and zero-extended otherwise.
- **Full product:** the signed product P has width W = din0_WIDTH + din1_WIDTH + 1 and is exact for all four modes.
- **Result interpretation:**
  - signed if either sgn_mode bit is 1;
  - unsigned if sgn_mode = 00.
- **dout_WIDTH >= W:** dout is P sign-extended; ovf = 0.
- **dout_WIDTH < W:** ovf = 1 when P lies outside the dout range for the result interpretation:
  - signed range: [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1];
  - unsigned range: [0, 2^dout_WIDTH-1].
- **SAT_MODE = 0:** dout = P[dout_WIDTH-1:0] regardless of ovf.
- **SAT_MODE = 1:** on overflow, dout clamps to the range max (P > max) or the range min (P < min). Otherwise dout = low bits.
- **Pipeline:**
  - NUM_STAGE stages, each holding a valid bit plus data.
  - Multiply and narrowing logic may be distributed freely, but the final stage registers dout/ovf directly. No combinational path from din* to dout.
- **Global stall:**
  - advance = !out_valid || out_ready.
  - When advance = 0, every stage holds; in_ready = advance (combinational from out_ready).
  - Bubbles are not collapsed.
- **Ordering:** results leave strictly in acceptance order; no duplication or loss.

## Timing

- **Reset values:** in_ready = 1 (after reset), out_valid = 0, dout = 0, ovf = 0. All stage valid bits are cleared asynchronously on ap_rst_n low. Internal data registers need no reset.
- **Latency:** with out_ready held high, a pair accepted at edge t gives out_valid = 1 with its dout/ovf from edge t+NUM_STAGE.
- **Throughput:** one result per cycle when unstalled.
- **Stall:** while out_valid && !out_ready, dout and ovf hold stable and no stage advances.
- **Simultaneous accept and retire:** when out_valid && out_ready and in_valid in the same cycle, both occur; occupancy is unchanged.
- **sgn_mode changes:** sgn_mode may change every cycle. Each result uses the mode captured with its own operands.
- **Reset mid-operation:**
  - In-flight items are discarded.
  - out_valid drops immediately (asynchronously).
  - No stale result appears after ap_rst_n returns high.
- **NUM_STAGE = 1:** a single register stage; result appears the cycle after acceptance.

## Test plan

1. Defaults, sgn_mode = 11, din0 = 14'h2000 (-8192), din1 = 12'h800 (-2048), out_ready = 1 -> out_valid exactly 3 cycles after accept, dout = 26'h1000000, ovf = 0.
2. Defaults, sgn_mode = 00, din0 = 14'h3FFF, din1 = 12'hFFF -> dout = 26'h3FFB001, ovf = 0. Then sgn_mode = 01, same operands (din0 = -1, din1 = 4095) -> dout = 26'h3FFF001, ovf = 0.
3. Narrowed result, din0_WIDTH = din1_WIDTH = dout_WIDTH = 8:
   - sgn_mode = 11, din0 = din1 = 8'h80 (16384): SAT_MODE = 1 -> dout = 8'h7F, ovf = 1; SAT_MODE = 0 -> dout = 8'h00, ovf = 1.
   - sgn_mode = 00, 200 × 2 (400): SAT_MODE = 1 -> dout = 8'hFF, ovf = 1.
   - sgn_mode = 11, 8'hF0 × 8'h08 (-128) -> dout = 8'h80, ovf = 0.
4. Backpressure:
   - Stimulus: 8 back-to-back pairs, out_ready low on cycles 4–6.
   - Required: in_ready low exactly on those cycles; dout/ovf stable while stalled.
   - Required: 8 results arrive in order, matching the reference model; none lost or repeated.
5. NUM_STAGE sweep 1, 2, 8 with random operands/modes and random out_ready -> latency equals NUM_STAGE when unstalled; all results match the model.
6. Reset mid-stream:
   - Stimulus: ap_rst_n pulsed low asynchronously with 3 items in flight.
   - Required: out_valid, dout and ovf go to 0 without a clock edge.
   - Required: after release, no output until new input, and the first new result is correct.
